instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / loader: accepts decoded RV32I instruction fields
// (R, I-ALU, LOAD, STORE, BRANCH), encodes them into 32-bit words and writes
// them sequentially into an instruction memory starting at word address 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a load session (honoured in IDLE/DONE only)
//   in_valid/ready    field handshake; ready only while accepting
//   in_class          0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH (5..7 illegal)
//   in_last           item ends the session
//   in_rd/rs1/rs2     register indices
//   in_funct3/funct7  function fields
//   in_imm            immediate (13 bits, BRANCH uses bit 12)
//   mem_we/addr/wdata instruction-memory write port
//   count             words written in this session
//   busy, done, err   status; err is sticky until the next start

module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic              in_last,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t      state;
    logic        last_q;
    logic        legal;
    logic [31:0] enc;

    // Status outputs are pure decodes of the state register, so they
    // change only on clock edges and need no extra flops.
    assign in_ready = (state == ACCEPT);
    assign busy     = (state == ACCEPT) || (state == WRITE);
    assign done     = (state == DONE);
    assign mem_we   = (state == WRITE);

    // Field packing per instruction class; fields a class does not use
    // never reach the encoded word.
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (in_class)
            3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3,
                         in_rd, 7'h33};
            3'd1: enc = {in_imm[11:0], in_rs1, in_funct3,
                         in_rd, 7'h13};
            3'd2: enc = {in_imm[11:0], in_rs1, in_funct3,
                         in_rd, 7'h03};
            3'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:0], 7'h23};
            3'd4: begin
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                         in_funct3, in_imm[4:1], in_imm[11], 7'h63};
                // Branch offsets are halfword aligned.
                legal = ~in_imm[0];
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            count     <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= ACCEPT;
                        mem_addr <= '0;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        if (legal) begin
                            mem_wdata <= enc;
                            last_q    <= in_last;
                            state     <= WRITE;
                        end else begin
                            // Illegal items are swallowed without a write.
                            err   <= 1'b1;
                            state <= in_last ? DONE : ACCEPT;
                        end
                    end
                end
                WRITE: begin
                    count <= count + (ADDR_W + 1)'(1);
                    // The top address ends the session; the pointer
                    // saturates instead of wrapping back to 0.
                    if (mem_addr == ADDR_MAX) begin
                        state <= DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= last_q ? DONE : ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (ADDR_W=2, 4-word memory).
// Directed items drive a session-level model that predicts every write.

module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_class = '0;
    logic          in_last = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [12:0]   in_imm = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_last   (in_last),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Session model
    logic [31:0] exp_data[$];
    int          exp_addr[$];
    int          m_addr = 0;
    int          m_count = 0;
    bit          m_err = 0;
    bit          m_done = 0;
    bit          m_active = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_enc(int unsigned cls,
        int unsigned rd, int unsigned rs1, int unsigned rs2,
        int unsigned f3, int unsigned f7, int unsigned imm);
        int unsigned w;
        int unsigned regs;
        regs = (rs1 << 15) + (f3 << 12);
        case (cls)
            0: w = (f7 << 25) + (rs2 << 20) + regs + (rd << 7) + 51;
            1: w = ((imm % 4096) << 20) + regs + (rd << 7) + 19;
            2: w = ((imm % 4096) << 20) + regs + (rd << 7) + 3;
            3: w = (((imm / 32) % 128) << 25) + (rs2 << 20) + regs
                   + ((imm % 32) << 7) + 35;
            default: w = (((imm / 4096) % 2) << 31)
                   + (((imm / 32) % 64) << 25) + (rs2 << 20) + regs
                   + (((imm / 2) % 16) << 8) + (((imm / 2048) % 2) << 7)
                   + 99;
        endcase
        return w;
    endfunction

    // Every write strobe must match the next predicted write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_data.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                chk("wr_addr", 32'(mem_addr), exp_addr.pop_front());
                chk("wr_data", mem_wdata, exp_data.pop_front());
            end
        end
        chk("we_and_done", 32'(mem_we & done), 32'd0);
    end

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_active || m_done) begin
            m_addr   = 0;
            m_count  = 0;
            m_err    = 0;
            m_done   = 0;
            m_active = 1;
        end
    endtask

    task automatic model_reset();
        m_addr   = 0;
        m_count  = 0;
        m_err    = 0;
        m_done   = 0;
        m_active = 0;
    endtask

    // Returns at the negedge after the handshake edge (the WRITE cycle
    // for a legal item).
    task automatic send(int unsigned cls, bit last, int unsigned rd,
        int unsigned rs1, int unsigned rs2, int unsigned f3,
        int unsigned f7, int unsigned imm);
        int n = 0;
        @(negedge clk);
        in_class  = 3'(cls);
        in_last   = last;
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 13'(imm);
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (cls <= 4 && !(cls == 4 && (imm % 2) == 1)) begin
            exp_addr.push_back(m_addr);
            exp_data.push_back(model_enc(cls, rd, rs1, rs2, f3, f7, imm));
            m_count++;
            if (last || m_addr == (1 << AW) - 1) m_done = 1;
            else m_addr++;
        end else begin
            m_err = 1;
            if (last) m_done = 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_model(string tag);
        chk({tag, "_count"}, 32'(count), 32'(m_count));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_ready"}, 32'(in_ready), 32'(m_active && !m_done));
        chk({tag, "_busy"}, 32'(busy), 32'(m_active && !m_done));
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        // Reset state, with start and in_valid held to show reset wins.
        start    = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check_zero("rst");
        rst_n = 1'b1;
        settle();
        check_model("idle");

        // R-type at address 0
        do_start();
        check_model("start");
        send(0, 0, 3, 1, 2, 0, 0, 13'h1fff);
        chk("r_word", mem_wdata, 32'h002081B3);
        chk("r_we", 32'(mem_we), 32'd1);
        settle();
        check_model("r");
        chk("r_addr_next", 32'(mem_addr), 32'd1);

        // start is ignored mid-session
        do_start();
        check_model("start_ignored");

        // I-ALU then STORE, garbage in unused fields
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_start();
        send(1, 0, 5, 0, 31, 0, 127, 13'h1fff);
        chk("i_word", mem_wdata, 32'hFFF00293);
        settle();
        send(3, 0, 31, 1, 2, 2, 85, 8);
        chk("s_word", mem_wdata, 32'h0020A423);
        settle();
        check_model("s");

        // BRANCH with last
        send(4, 1, 17, 1, 2, 0, 99, 13'h1ffc);
        chk("b_word", mem_wdata, 32'hFE208EE3);
        settle();
        check_model("b_done");

        // Illegal items, then fill all four words
        do_start();
        send(5, 0, 1, 2, 3, 4, 5, 6);
        send(4, 0, 0, 1, 2, 0, 0, 3);
        settle();
        check_model("illegal");
        chk("illegal_wdata", mem_wdata, 32'hFE208EE3);
        send(2, 0, 7, 8, 9, 2, 3, 13'h123);
        settle();
        send(0, 0, 31, 30, 29, 7, 32, 0);
        settle();
        send(1, 0, 1, 2, 3, 4, 5, 13'h800);
        settle();
        check_model("three");
        send(4, 0, 0, 4, 5, 1, 0, 13'h0ffe);
        settle();
        check_model("full");
        chk("full_count", 32'(count), 32'd4);
        chk("full_done", 32'(done), 32'd1);

        // Restart clears err and count
        do_start();
        check_model("restart");
        send(3, 1, 0, 3, 4, 1, 0, 13'h0fff);
        settle();
        check_model("restart_done");

        // Illegal last item ends the session
        do_start();
        send(7, 1, 0, 0, 0, 0, 0, 0);
        settle();
        check_model("ill_last");

        // Reset in the WRITE cycle
        do_start();
        send(0, 0, 9, 10, 11, 3, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_write");
        rst_n = 1'b1;
        model_reset();
        in_valid = 1'b1;
        in_class = 3'd0;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        settle();

        chk("pending_writes", 32'(exp_data.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
